ddr3_req_arbiter: RTL and testbench
===================================

Name: ddr3_req_arbiter

Overview:
Sits between user requesters and ddr3_controller in the pclk (1:4) domain. Arbitrates two single-word requester ports (round-robin) plus an internal tREFI refresh scheduler. Issues at most one rd/wr/refresh pulse to the controller at a time, tracks busy/data_ready, and returns read data to the owning port. Replaces ad-hoc refresh_needed/refresh_executed logic in test tops.

Parameters:
REFRESH_CYCLES, 614, pclk cycles per tREFI (7.8 us at 78.75 MHz)
URGENT_PENDING, 4, pending refreshes at which refresh beats user requests
MAX_PENDING, 8, JEDEC postpone limit; pending counter saturates here
ADDR_W, 26, word address width

Ports:
pclk  in  1  controller user clock
resetn  in  1  asynchronous active-low reset
init_done  in  1  controller init/calibration complete
p0_req  in  1  port 0 request, held with fields stable until p0_ack
p0_we  in  1  1=write, 0=read
p0_addr  in  ADDR_W  word address
p0_wdata  in  16  write data
p0_ack  out  1  one-cycle pulse: command issued
p0_rvalid  out  1  one-cycle pulse: p0_rdata valid
p0_rdata  out  16  read data
p1_req/p1_we/p1_addr/p1_wdata/p1_ack/p1_rvalid/p1_rdata  same as port 0
ctrl_rd, ctrl_wr, ctrl_refresh  out  1 each  one-cycle command pulses
ctrl_addr  out  ADDR_W  address, valid with pulse
ctrl_din  out  16  write data, valid with pulse
ctrl_busy  in  1  controller busy
ctrl_data_ready  in  1  read data strobe
ctrl_dout  in  16  controller read word
refresh_overrun  out  1  sticky: pending hit MAX_PENDING
stat_refresh, stat_p0, stat_p1  out  24 each  event counters (see feature)

Behaviour:
- Reset: all outputs 0; state IDLE; timer 0; pending 0; rr pointer = port 0.
- Refresh timer: counts only when init_done; at REFRESH_CYCLES-1 wraps to 0 and pending++ (saturating at MAX_PENDING). Issuing a refresh: pending--. Increment and decrement in same cycle: pending unchanged.
- refresh_overrun sets when pending reaches MAX_PENDING; cleared only by reset.
- FSM: IDLE -> ISSUE -> BLANK -> WAIT -> IDLE.
- IDLE (requires init_done && !ctrl_busy): priority 1) pending >= URGENT_PENDING -> refresh; 2) user request, round-robin (if both, grant port != last granted); 3) pending > 0 -> refresh; else stay.
- ISSUE (1 cycle): exactly one of ctrl_rd/ctrl_wr/ctrl_refresh high with ctrl_addr/ctrl_din; granted port's ack pulses the same cycle; rr pointer updates.
- BLANK: one cycle ignoring ctrl_busy (controller raises busy one cycle after a command).
- WAIT: refresh/write exit when ctrl_busy==0; read exits when ctrl_busy==0 and data_ready seen (may precede busy drop). On ctrl_data_ready: capture ctrl_dout into owner's rdata, pulse owner's rvalid next cycle.
- Unsolicited ctrl_data_ready (no read outstanding): ignored.
- Max throughput: one command per 4 cycles plus controller busy time.
- Request dropped before ack: not issued (fields sampled only in IDLE).
- init_done falling mid-operation: current command completes; no new grants.
- Reset mid-operation: immediate return to reset state; in-flight read data discarded.

Optional Feature:
DDR3_ARB_STATS_EN: defined -> stat_refresh/stat_p0/stat_p1 count issued refreshes and per-port acks, 24-bit wrapping, cleared by reset. Undefined -> stat outputs tied to 0, counters not built.

Decomposition:
Package ddr3_arb_pkg: cmd enum (CMD_NONE, CMD_RD, CMD_WR, CMD_REF), FSM state enum, owner enum (OWN_P0, OWN_P1, OWN_REF), default REFRESH_CYCLES. Sub-module ddr3_refresh_sched (timer, pending counter, overrun flag, urgent/any outputs, issued input).

Test Plan:
- Reset, init_done=1, no requests, model busy 10 cycles per cmd -> first ctrl_refresh at cycle ~615, every 614 cycles thereafter; refresh_overrun=0.
- p0 write addr 0x0001 data 0x5678 -> ctrl_wr 1 cycle with ctrl_addr=0x0001, ctrl_din=0x5678, p0_ack same cycle; p0_rvalid never.
- p1 read addr 0x0002, model returns 0xABCD -> p1_rvalid one pulse, p1_rdata=0xABCD; p0_rvalid stays 0.
- p0 and p1 requesting continuously -> grants alternate p0,p1,p0,p1; neither starved.
- Both ports saturating, busy 700 cycles per cmd -> refresh preempts when pending reaches 4; pending never exceeds 8; if forced to 8, refresh_overrun sticks at 1.
- Assert resetn low during WAIT of read -> all outputs 0 immediately; stale data_ready after release produces no rvalid.

Source files
------------

// File: rtl/ddr3_arb_pkg.sv
// Shared types for the DDR3 request arbiter: command, FSM state and owner encodings,
// plus the default tREFI period in pclk cycles.
package ddr3_arb_pkg;

  localparam int DEF_REFRESH_CYCLES = 614;

  typedef enum logic [1:0] {CMD_NONE, CMD_RD, CMD_WR, CMD_REF} cmd_t;
  typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_BLANK, ST_WAIT} state_t;
  typedef enum logic [1:0] {OWN_P0, OWN_P1, OWN_REF} owner_t;

endpackage

// File: rtl/ddr3_req_arbiter_if.sv
// Bus bundle between the two user requesters, the arbiter and ddr3_controller.
// slave = arbiter view, master = requesters plus controller view.
interface ddr3_req_arbiter_if #(
  parameter int ADDR_W = 26
);
  logic              init_done;
  logic              p0_req, p0_we, p0_ack, p0_rvalid;
  logic [ADDR_W-1:0] p0_addr;
  logic [15:0]       p0_wdata, p0_rdata;
  logic              p1_req, p1_we, p1_ack, p1_rvalid;
  logic [ADDR_W-1:0] p1_addr;
  logic [15:0]       p1_wdata, p1_rdata;
  logic              ctrl_rd, ctrl_wr, ctrl_refresh;
  logic [ADDR_W-1:0] ctrl_addr;
  logic [15:0]       ctrl_din, ctrl_dout;
  logic              ctrl_busy, ctrl_data_ready;
  logic              refresh_overrun;
  logic [23:0]       stat_refresh, stat_p0, stat_p1;

  modport slave (
    input  init_done,
    input  p0_req, p0_we, p0_addr, p0_wdata,
    output p0_ack, p0_rvalid, p0_rdata,
    input  p1_req, p1_we, p1_addr, p1_wdata,
    output p1_ack, p1_rvalid, p1_rdata,
    output ctrl_rd, ctrl_wr, ctrl_refresh, ctrl_addr, ctrl_din,
    input  ctrl_busy, ctrl_data_ready, ctrl_dout,
    output refresh_overrun, stat_refresh, stat_p0, stat_p1
  );

  modport master (
    output init_done,
    output p0_req, p0_we, p0_addr, p0_wdata,
    input  p0_ack, p0_rvalid, p0_rdata,
    output p1_req, p1_we, p1_addr, p1_wdata,
    input  p1_ack, p1_rvalid, p1_rdata,
    input  ctrl_rd, ctrl_wr, ctrl_refresh, ctrl_addr, ctrl_din,
    output ctrl_busy, ctrl_data_ready, ctrl_dout,
    input  refresh_overrun, stat_refresh, stat_p0, stat_p1
  );
endinterface

// File: rtl/ddr3_refresh_sched.sv
// tREFI refresh scheduler: interval timer, saturating pending-refresh counter and
// sticky overrun flag once the JEDEC postpone limit is reached.
module ddr3_refresh_sched
  import ddr3_arb_pkg::*;
#(
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int URGENT_PENDING = 4,
  parameter int MAX_PENDING    = 8
) (
  input  logic pclk,
  input  logic resetn,
  input  logic init_done,
  input  logic issued,
  output logic urgent,
  output logic any,
  output logic overrun
);
  localparam int TW = $clog2(REFRESH_CYCLES);
  localparam int PW = $clog2(MAX_PENDING + 1);

  logic [TW-1:0] timer;
  logic [PW-1:0] pending, pending_nxt;
  logic          tick;

  assign tick = init_done && (timer == TW'(REFRESH_CYCLES - 1));

  // A tick and an issue in the same cycle cancel out, even at saturation.
  always_comb begin
    pending_nxt = pending;
    if (tick && !issued && pending != PW'(MAX_PENDING))
      pending_nxt = pending + PW'(1);
    else if (issued && !tick && pending != '0)
      pending_nxt = pending - PW'(1);
  end

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      timer   <= '0;
      pending <= '0;
      overrun <= 1'b0;
    end else begin
      if (init_done) timer <= tick ? '0 : timer + TW'(1);
      pending <= pending_nxt;
      if (pending_nxt == PW'(MAX_PENDING)) overrun <= 1'b1;
    end
  end

  assign urgent = (pending >= PW'(URGENT_PENDING));
  assign any    = (pending != '0);

endmodule

// File: rtl/ddr3_req_arbiter.sv
// Round-robin arbiter for two single-word user ports plus tREFI refresh in front of
// ddr3_controller. Define DDR3_ARB_STATS_EN to build the 24-bit event counters.
module ddr3_req_arbiter
  import ddr3_arb_pkg::*;
#(
  parameter int REFRESH_CYCLES = DEF_REFRESH_CYCLES,
  parameter int URGENT_PENDING = 4,
  parameter int MAX_PENDING    = 8,
  parameter int ADDR_W         = 26
) (
  input  logic               pclk,
  input  logic               resetn,
  ddr3_req_arbiter_if.slave  bus
);
  state_t            state;
  owner_t            owner;
  cmd_t              cmd;
  logic              rr;        // 0: port 0 has priority on a tie, 1: port 1
  logic              rd_seen;
  logic              rd_q, wr_q, ref_q, ack0_q, ack1_q, rv0_q, rv1_q;
  logic [ADDR_W-1:0] addr_q;
  logic [15:0]       din_q, rdata0_q, rdata1_q;
  logic              ref_urgent, ref_any;
  logic              user_req, grant_p1, sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [15:0]       sel_wdata;

  ddr3_refresh_sched #(
    .REFRESH_CYCLES (REFRESH_CYCLES),
    .URGENT_PENDING (URGENT_PENDING),
    .MAX_PENDING    (MAX_PENDING)
  ) u_sched (
    .pclk      (pclk),
    .resetn    (resetn),
    .init_done (bus.init_done),
    .issued    (ref_q),
    .urgent    (ref_urgent),
    .any       (ref_any),
    .overrun   (bus.refresh_overrun)
  );

  assign user_req  = bus.p0_req || bus.p1_req;
  assign grant_p1  = bus.p1_req && (!bus.p0_req || rr);
  assign sel_we    = grant_p1 ? bus.p1_we    : bus.p0_we;
  assign sel_addr  = grant_p1 ? bus.p1_addr  : bus.p0_addr;
  assign sel_wdata = grant_p1 ? bus.p1_wdata : bus.p0_wdata;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      owner    <= OWN_P0;
      cmd      <= CMD_NONE;
      rr       <= 1'b0;
      rd_seen  <= 1'b0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      ref_q    <= 1'b0;
      ack0_q   <= 1'b0;
      ack1_q   <= 1'b0;
      rv0_q    <= 1'b0;
      rv1_q    <= 1'b0;
      addr_q   <= '0;
      din_q    <= '0;
      rdata0_q <= '0;
      rdata1_q <= '0;
    end else begin
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      ref_q  <= 1'b0;
      ack0_q <= 1'b0;
      ack1_q <= 1'b0;
      rv0_q  <= 1'b0;
      rv1_q  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (bus.init_done && !bus.ctrl_busy) begin
            if (ref_urgent || (!user_req && ref_any)) begin
              ref_q  <= 1'b1;
              cmd    <= CMD_REF;
              owner  <= OWN_REF;
              addr_q <= '0;
              din_q  <= '0;
              state  <= ST_ISSUE;
            end else if (user_req) begin
              rd_q    <= !sel_we;
              wr_q    <= sel_we;
              cmd     <= sel_we ? CMD_WR : CMD_RD;
              owner   <= grant_p1 ? OWN_P1 : OWN_P0;
              ack0_q  <= !grant_p1;
              ack1_q  <= grant_p1;
              rr      <= !grant_p1;
              rd_seen <= 1'b0;
              addr_q  <= sel_addr;
              din_q   <= sel_wdata;
              state   <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state <= ST_BLANK;
        // Controller raises busy one cycle late, so it is not trusted here.
        ST_BLANK: state <= ST_WAIT;
        ST_WAIT: begin
          if (!bus.ctrl_busy && (cmd != CMD_RD || rd_seen || bus.ctrl_data_ready)) begin
            state <= ST_IDLE;
            cmd   <= CMD_NONE;
          end
        end
      endcase

      // Only the first strobe of an outstanding read is returned; anything else is stray.
      if (cmd == CMD_RD && !rd_seen && bus.ctrl_data_ready && state != ST_IDLE) begin
        rd_seen <= 1'b1;
        if (owner == OWN_P1) begin
          rdata1_q <= bus.ctrl_dout;
          rv1_q    <= 1'b1;
        end else begin
          rdata0_q <= bus.ctrl_dout;
          rv0_q    <= 1'b1;
        end
      end
    end
  end

  assign bus.ctrl_rd      = rd_q;
  assign bus.ctrl_wr      = wr_q;
  assign bus.ctrl_refresh = ref_q;
  assign bus.ctrl_addr    = addr_q;
  assign bus.ctrl_din     = din_q;
  assign bus.p0_ack       = ack0_q;
  assign bus.p1_ack       = ack1_q;
  assign bus.p0_rvalid    = rv0_q;
  assign bus.p1_rvalid    = rv1_q;
  assign bus.p0_rdata     = rdata0_q;
  assign bus.p1_rdata     = rdata1_q;

`ifdef DDR3_ARB_STATS_EN
  logic [23:0] cnt_ref, cnt_p0, cnt_p1;

  always_ff @(posedge pclk or negedge resetn) begin
    if (!resetn) begin
      cnt_ref <= '0;
      cnt_p0  <= '0;
      cnt_p1  <= '0;
    end else begin
      if (ref_q)  cnt_ref <= cnt_ref + 24'd1;
      if (ack0_q) cnt_p0  <= cnt_p0 + 24'd1;
      if (ack1_q) cnt_p1  <= cnt_p1 + 24'd1;
    end
  end

  assign bus.stat_refresh = cnt_ref;
  assign bus.stat_p0      = cnt_p0;
  assign bus.stat_p1      = cnt_p1;
`else
  assign bus.stat_refresh = '0;
  assign bus.stat_p0      = '0;
  assign bus.stat_p1      = '0;
`endif

endmodule

// File: tb/tb_ddr3_req_arbiter.sv
// Directed bench for ddr3_req_arbiter with a small behavioural ddr3_controller
// (busy window per command, delayed read strobe).
`timescale 1ns/1ps
module tb_ddr3_req_arbiter;

  logic pclk = 1'b0;
  logic resetn = 1'b0;
  always #5 pclk = ~pclk;

  ddr3_req_arbiter_if #(.ADDR_W(26)) ifc ();

  ddr3_req_arbiter dut (
    .pclk   (pclk),
    .resetn (resetn),
    .bus    (ifc)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int t_init  = 0;

  always @(posedge pclk) cyc <= cyc + 1;

  // Controller model knobs (written by the test tasks only).
  int          busy_len  = 10;
  int          rd_lat    = 3;
  logic [15:0] rd_word   = 16'h0;
  logic        hold_busy = 1'b0;
  logic        inject_dr = 1'b0;

  // Controller model state and event logs (written by the model only).
  logic        model_busy = 1'b0;
  logic        model_dr   = 1'b0;
  logic [15:0] model_dout = 16'h0;
  int busy_cnt, rd_cnt, n_cmd, n_ref, n_wr, n_grant, n_rv0, n_rv1;
  int cmd_log [0:63];
  int grant_log [0:63];
  int ref_cyc [0:15];

  assign ifc.ctrl_busy       = model_busy | hold_busy;
  assign ifc.ctrl_data_ready = model_dr | inject_dr;
  assign ifc.ctrl_dout       = model_dout;

  initial begin
    forever begin
      @(posedge pclk); #1;
      if (!resetn) begin
        busy_cnt = 0; rd_cnt = 0; n_cmd = 0; n_ref = 0; n_wr = 0;
        n_grant = 0; n_rv0 = 0; n_rv1 = 0;
        model_busy = 1'b0; model_dr = 1'b0;
      end else begin
        model_dr = 1'b0;
        if (rd_cnt > 0) begin
          rd_cnt--;
          if (rd_cnt == 0) begin model_dr = 1'b1; model_dout = rd_word; end
        end
        if (ifc.ctrl_rd || ifc.ctrl_wr || ifc.ctrl_refresh) begin
          busy_cnt = busy_len;
          if (ifc.ctrl_rd) rd_cnt = rd_lat;
          if (n_cmd < 64) cmd_log[n_cmd] = ifc.ctrl_rd ? 0 : (ifc.ctrl_wr ? 1 : 2);
          n_cmd++;
          if (ifc.ctrl_refresh) begin
            if (n_ref < 16) ref_cyc[n_ref] = cyc;
            n_ref++;
          end
          if (ifc.ctrl_wr) n_wr++;
        end
        if (ifc.p0_ack) begin if (n_grant < 64) grant_log[n_grant] = 0; n_grant++; end
        if (ifc.p1_ack) begin if (n_grant < 64) grant_log[n_grant] = 1; n_grant++; end
        if (ifc.p0_rvalid) n_rv0++;
        if (ifc.p1_rvalid) n_rv1++;
        model_busy = (busy_cnt > 0);
        if (busy_cnt > 0) busy_cnt--;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge pclk);
    #1;
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin @(posedge pclk); #1; end
  endtask

  task automatic do_reset();
    resetn = 1'b0; ifc.init_done = 1'b0;
    ifc.p0_req = 1'b0; ifc.p0_we = 1'b0; ifc.p0_addr = '0; ifc.p0_wdata = '0;
    ifc.p1_req = 1'b0; ifc.p1_we = 1'b0; ifc.p1_addr = '0; ifc.p1_wdata = '0;
    hold_busy = 1'b0; inject_dr = 1'b0; busy_len = 10; rd_lat = 3;
    wait_cycles(2);
  endtask

  task automatic release_reset();
    resetn = 1'b1;
    wait_cycles(1);
    ifc.init_done = 1'b1;
    t_init = cyc;
  endtask

  task automatic test_reset();
    do_reset();
    n_tests++;
    if ({ifc.ctrl_rd, ifc.ctrl_wr, ifc.ctrl_refresh} !== 3'b000) begin
      n_fail++; $display("FAIL reset_cmds got %b expected 000", {ifc.ctrl_rd, ifc.ctrl_wr, ifc.ctrl_refresh});
    end
    n_tests++;
    if ({ifc.p0_ack, ifc.p1_ack, ifc.p0_rvalid, ifc.p1_rvalid} !== 4'b0000) begin
      n_fail++; $display("FAIL reset_acks got %b expected 0000", {ifc.p0_ack, ifc.p1_ack, ifc.p0_rvalid, ifc.p1_rvalid});
    end
    n_tests++;
    if ({ifc.p0_rdata, ifc.p1_rdata, ifc.ctrl_din} !== 48'h0) begin
      n_fail++; $display("FAIL reset_data got %h expected 0", {ifc.p0_rdata, ifc.p1_rdata, ifc.ctrl_din});
    end
    n_tests++;
    if (ifc.ctrl_addr !== 26'h0) begin
      n_fail++; $display("FAIL reset_addr got %h expected 0", ifc.ctrl_addr);
    end
    n_tests++;
    if (ifc.refresh_overrun !== 1'b0) begin
      n_fail++; $display("FAIL reset_overrun got %b expected 0", ifc.refresh_overrun);
    end
    n_tests++;
    if ({ifc.stat_refresh, ifc.stat_p0, ifc.stat_p1} !== 72'h0) begin
      n_fail++; $display("FAIL reset_stats got %h expected 0", {ifc.stat_refresh, ifc.stat_p0, ifc.stat_p1});
    end
  endtask

  task automatic test_refresh_period();
    do_reset(); release_reset();
    for (int i = 0; i < 1400 && n_ref < 2; i++) wait_cycles(1);
    n_tests++;
    if (n_ref < 2) begin
      n_fail++; $display("FAIL refresh_timeout got %0d refreshes expected 2", n_ref);
    end else begin
      n_tests++;
      if (ref_cyc[0] - t_init != 615) begin
        n_fail++; $display("FAIL refresh_first got %0d cycles expected 615", ref_cyc[0] - t_init);
      end
      n_tests++;
      if (ref_cyc[1] - ref_cyc[0] != 614) begin
        n_fail++; $display("FAIL refresh_interval got %0d cycles expected 614", ref_cyc[1] - ref_cyc[0]);
      end
    end
    n_tests++;
    if (ifc.refresh_overrun !== 1'b0) begin
      n_fail++; $display("FAIL refresh_no_overrun got %b expected 0", ifc.refresh_overrun);
    end
  endtask

  task automatic test_write();
    bit ok = 0;
    do_reset(); release_reset();
    ifc.p0_we = 1'b1; ifc.p0_addr = 26'h1; ifc.p0_wdata = 16'h5678; ifc.p0_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      if (ifc.p0_ack) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok) begin
      n_fail++; $display("FAIL wr_ack_timeout got none expected p0_ack");
    end else begin
      n_tests++;
      if ({ifc.ctrl_rd, ifc.ctrl_wr, ifc.ctrl_refresh, ifc.p1_ack} !== 4'b0100) begin
        n_fail++; $display("FAIL wr_pulse got %b expected 0100", {ifc.ctrl_rd, ifc.ctrl_wr, ifc.ctrl_refresh, ifc.p1_ack});
      end
      n_tests++;
      if (ifc.ctrl_addr !== 26'h1 || ifc.ctrl_din !== 16'h5678) begin
        n_fail++; $display("FAIL wr_fields got %h/%h expected 1/5678", ifc.ctrl_addr, ifc.ctrl_din);
      end
    end
    ifc.p0_req = 1'b0;
    wait_cycles(1);
    n_tests++;
    if (ifc.ctrl_wr !== 1'b0) begin
      n_fail++; $display("FAIL wr_one_cycle got %b expected 0", ifc.ctrl_wr);
    end
    wait_cycles(30);
    n_tests++;
    if (n_wr != 1 || n_rv0 != 0 || n_rv1 != 0) begin
      n_fail++; $display("FAIL wr_after got wr=%0d rv0=%0d rv1=%0d expected 1/0/0", n_wr, n_rv0, n_rv1);
    end
  endtask

  task automatic test_read();
    bit ok = 0;
    do_reset(); release_reset();
    rd_word = 16'hABCD;
    ifc.p1_we = 1'b0; ifc.p1_addr = 26'h2; ifc.p1_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      if (ifc.p1_ack) begin ok = 1; break; end
    end
    n_tests++;
    if (!ok || ifc.ctrl_rd !== 1'b1 || ifc.ctrl_addr !== 26'h2) begin
      n_fail++; $display("FAIL rd_issue got ack=%0d rd=%b addr=%h expected 1/1/2", ok, ifc.ctrl_rd, ifc.ctrl_addr);
    end
    ifc.p1_req = 1'b0;
    wait_cycles(40);
    n_tests++;
    if (n_rv1 != 1) begin
      n_fail++; $display("FAIL rd_rvalid_count got %0d expected 1", n_rv1);
    end
    n_tests++;
    if (ifc.p1_rdata !== 16'hABCD) begin
      n_fail++; $display("FAIL rd_data got %h expected abcd", ifc.p1_rdata);
    end
    n_tests++;
    if (n_rv0 != 0) begin
      n_fail++; $display("FAIL rd_p0_quiet got %0d expected 0", n_rv0);
    end
  endtask

  task automatic test_back_to_back();
    do_reset(); release_reset();
    busy_len = 2;
    ifc.p0_we = 1'b1; ifc.p0_addr = 26'h10; ifc.p0_wdata = 16'h1111; ifc.p0_req = 1'b1;
    ifc.p1_we = 1'b1; ifc.p1_addr = 26'h20; ifc.p1_wdata = 16'h2222; ifc.p1_req = 1'b1;
    for (int i = 0; i < 200 && n_grant < 6; i++) wait_cycles(1);
    ifc.p0_req = 1'b0; ifc.p1_req = 1'b0;
    n_tests++;
    if (n_grant < 6) begin
      n_fail++; $display("FAIL rr_timeout got %0d grants expected 6", n_grant);
    end else begin
      for (int i = 0; i < 6; i++) begin
        n_tests++;
        if (grant_log[i] != (i % 2)) begin
          n_fail++; $display("FAIL rr_grant%0d got p%0d expected p%0d", i, grant_log[i], i % 2);
        end
      end
    end
    wait_cycles(20);
  endtask

  task automatic test_urgent();
    do_reset();
    hold_busy = 1'b1;
    release_reset();
    ifc.p0_we = 1'b1; ifc.p0_addr = 26'h30; ifc.p0_wdata = 16'h3333; ifc.p0_req = 1'b1;
    ifc.p1_we = 1'b1; ifc.p1_addr = 26'h40; ifc.p1_wdata = 16'h4444; ifc.p1_req = 1'b1;
    wait_until(t_init + 4 * 614 + 3);
    n_tests++;
    if (n_cmd != 0) begin
      n_fail++; $display("FAIL urg_held got %0d cmds expected 0", n_cmd);
    end
    hold_busy = 1'b0;
    for (int i = 0; i < 200 && n_cmd < 3; i++) wait_cycles(1);
    ifc.p0_req = 1'b0; ifc.p1_req = 1'b0;
    n_tests++;
    if (n_cmd < 3) begin
      n_fail++; $display("FAIL urg_timeout got %0d cmds expected 3", n_cmd);
    end else begin
      n_tests++;
      if (cmd_log[0] != 2) begin
        n_fail++; $display("FAIL urg_first got %0d expected 2 (refresh)", cmd_log[0]);
      end
      n_tests++;
      if (cmd_log[1] != 1 || cmd_log[2] != 1) begin
        n_fail++; $display("FAIL urg_users got %0d,%0d expected 1,1", cmd_log[1], cmd_log[2]);
      end
      n_tests++;
      if (grant_log[0] != 0 || grant_log[1] != 1) begin
        n_fail++; $display("FAIL urg_order got p%0d,p%0d expected p0,p1", grant_log[0], grant_log[1]);
      end
    end
    wait_cycles(20);
  endtask

  task automatic test_overrun();
    do_reset();
    hold_busy = 1'b1;
    release_reset();
    wait_until(t_init + 7 * 614 + 5);
    n_tests++;
    if (ifc.refresh_overrun !== 1'b0) begin
      n_fail++; $display("FAIL ovr_at7 got %b expected 0", ifc.refresh_overrun);
    end
    wait_until(t_init + 8 * 614 + 5);
    n_tests++;
    if (ifc.refresh_overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_at8 got %b expected 1", ifc.refresh_overrun);
    end
    wait_until(t_init + 8 * 614 + 10);
    hold_busy = 1'b0;
    wait_until(t_init + 5400);
    n_tests++;
    if (n_ref != 8) begin
      n_fail++; $display("FAIL ovr_drain got %0d refreshes expected 8", n_ref);
    end
    n_tests++;
    if (ifc.refresh_overrun !== 1'b1) begin
      n_fail++; $display("FAIL ovr_sticky got %b expected 1", ifc.refresh_overrun);
    end
  endtask

  task automatic test_reset_mid_read();
    bit ok = 0;
    do_reset(); release_reset();
    rd_word = 16'h1234;
    ifc.p0_we = 1'b0; ifc.p0_addr = 26'h5; ifc.p0_req = 1'b1;
    for (int i = 0; i < 20 && !ifc.p0_ack; i++) wait_cycles(1);
    ifc.p0_req = 1'b0;
    wait_cycles(30);
    n_tests++;
    if (n_rv0 != 1 || ifc.p0_rdata !== 16'h1234) begin
      n_fail++; $display("FAIL mid_first_read got rv=%0d data=%h expected 1/1234", n_rv0, ifc.p0_rdata);
    end
    rd_lat = 15; busy_len = 30; rd_word = 16'h9999;
    ifc.p0_addr = 26'h6; ifc.p0_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      wait_cycles(1);
      if (ifc.p0_ack) begin ok = 1; break; end
    end
    ifc.p0_req = 1'b0;
    wait_cycles(4);
    resetn = 1'b0;
    #1;
    n_tests++;
    if (!ok || ifc.p0_rdata !== 16'h0 || ifc.ctrl_addr !== 26'h0) begin
      n_fail++; $display("FAIL mid_async_clear got ack=%0d rdata=%h addr=%h expected 1/0/0", ok, ifc.p0_rdata, ifc.ctrl_addr);
    end
    wait_cycles(2);
    release_reset();
    inject_dr = 1'b1;
    wait_cycles(1);
    inject_dr = 1'b0;
    wait_cycles(10);
    n_tests++;
    if (n_rv0 != 0 || n_rv1 != 0) begin
      n_fail++; $display("FAIL mid_stale_dr got rv0=%0d rv1=%0d expected 0/0", n_rv0, n_rv1);
    end
  endtask

  task automatic test_init_drop();
    do_reset(); release_reset();
    ifc.init_done = 1'b0;
    ifc.p0_we = 1'b1; ifc.p0_addr = 26'h7; ifc.p0_wdata = 16'h7777; ifc.p0_req = 1'b1;
    wait_cycles(20);
    n_tests++;
    if (n_grant != 0) begin
      n_fail++; $display("FAIL init_low_grant got %0d expected 0", n_grant);
    end
    ifc.init_done = 1'b1;
    for (int i = 0; i < 10 && n_grant == 0; i++) wait_cycles(1);
    ifc.p0_req = 1'b0;
    n_tests++;
    if (n_grant != 1 || grant_log[0] != 0) begin
      n_fail++; $display("FAIL init_high_grant got %0d expected 1", n_grant);
    end
    wait_cycles(20);
  endtask

  initial begin
    test_reset();
    test_refresh_period();
    test_write();
    test_read();
    test_back_to_back();
    test_urgent();
    test_overrun();
    test_reset_mid_read();
    test_init_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
